// File: rtl/risc_controller.sv
// Eight-phase sequencer for a simple accumulator RISC core.
// Decodes bus/register strobes from phase, opcode and the zero flag.
module risc_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [2:0]  opcode,
  input  logic        zero,
  input  logic        resume,
  output logic        sel,
  output logic        rd,
  output logic        ld_ir,
  output logic        inc_pc,
  output logic        halt,
  output logic        ld_pc,
  output logic        data_e,
  output logic        ld_ac,
  output logic        wr,
  output logic [2:0]  phase,
  output logic        halted,
  output logic [15:0] retired
);

  localparam logic [2:0] OpHlt = 3'd0;
  localparam logic [2:0] OpSkz = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpAnd = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpLda = 3'd5;
  localparam logic [2:0] OpSto = 3'd6;
  localparam logic [2:0] OpJmp = 3'd7;

  typedef enum logic [2:0] {
    StInstAddr  = 3'd0,
    StInstFetch = 3'd1,
    StInstLoad  = 3'd2,
    StIdle      = 3'd3,
    StOpAddr    = 3'd4,
    StOpFetch   = 3'd5,
    StAluOp     = 3'd6,
    StStore     = 3'd7
  } phase_e;

  phase_e      phase_q;
  logic        halted_q;
  logic [15:0] retired_q;
  logic        is_aluop;

  assign is_aluop = (opcode == OpAdd) || (opcode == OpAnd) ||
                    (opcode == OpXor) || (opcode == OpLda);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= StInstAddr;
      halted_q  <= 1'b0;
      retired_q <= 16'd0;
    end else if (halted_q) begin
      // Halt ignores en; only resume releases it, restarting a fresh fetch.
      if (resume) begin
        halted_q <= 1'b0;
        phase_q  <= StInstAddr;
      end
    end else if (en) begin
      if (phase_q == StOpAddr && opcode == OpHlt) begin
        halted_q <= 1'b1;
      end else begin
        phase_q <= phase_e'(phase_q + 3'd1);
        if (phase_q == StStore) begin
          retired_q <= retired_q + 16'd1;
        end
      end
    end
  end

  assign phase   = phase_q;
  assign halted  = halted_q;
  assign retired = retired_q;

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    unique case (phase_q)
      StInstAddr: begin
        sel = 1'b1;
      end
      StInstFetch: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      StInstLoad, StIdle: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      StOpAddr: begin
        inc_pc = 1'b1;
        halt   = (opcode == OpHlt);
      end
      StOpFetch: begin
        rd = is_aluop;
      end
      StAluOp: begin
        rd     = is_aluop;
        inc_pc = (opcode == OpSkz) && zero;
        ld_pc  = (opcode == OpJmp);
        data_e = (opcode == OpSto);
      end
      StStore: begin
        rd     = is_aluop;
        ld_ac  = is_aluop;
        ld_pc  = (opcode == OpJmp);
        wr     = (opcode == OpSto);
        data_e = (opcode == OpSto);
      end
      default: ;
    endcase

    // Register-update strobes must not fire while the phase is frozen.
    if (!en) begin
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
    end

    if (halted_q) begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      halt   = 1'b1;
      ld_pc  = 1'b0;
      data_e = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
    end
  end

endmodule

// File: tb/tb_risc_controller.sv
// Bench for risc_controller: directed scenarios plus a randomized run
// against a phase/halt/instruction-count reference model.
module tb_risc_controller;

  logic        clk = 1'b0;
  logic        rst_n, en, zero, resume;
  logic [2:0]  opcode;
  logic        sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, halted;
  logic [2:0]  phase;
  logic [15:0] retired;
  logic [8:0]  ctrl;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_phase   = 0;
  bit m_halted  = 1'b0;
  int m_retired = 0;

  risc_controller dut (
    .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .zero(zero), .resume(resume),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .halt(halt), .ld_pc(ld_pc),
    .data_e(data_e), .ld_ac(ld_ac), .wr(wr), .phase(phase), .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // Bit order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
  assign ctrl = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

  function automatic logic [8:0] exp_ctrl(int ph, bit hlt, logic [2:0] op, logic z, logic e);
    bit alu, s, r, li, ip, h, lp, de, la, w;
    alu = (op >= 3'd2 && op <= 3'd5);
    {s, r, li, ip, h, lp, de, la, w} = '0;
    if (hlt) return 9'b0_0001_0000;
    case (ph)
      0: s = 1;
      1: begin s = 1; r = 1; end
      2, 3: begin s = 1; r = 1; li = 1; end
      4: begin ip = 1; h = (op == 3'd0); end
      5: r = alu;
      6: begin r = alu; ip = (op == 3'd1) && z; lp = (op == 3'd7); de = (op == 3'd6); end
      default: begin
        r = alu; la = alu; lp = (op == 3'd7); w = (op == 3'd6); de = (op == 3'd6);
      end
    endcase
    if (!e) begin li = 0; ip = 0; lp = 0; la = 0; w = 0; end
    return {s, r, li, ip, h, lp, de, la, w};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_halted = 1'b0; m_retired = 0;
  endtask

  // Advance one clock and apply the instruction-cycle rules to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (m_halted) begin
      if (resume) begin m_halted = 1'b0; m_phase = 0; end
    end else if (en) begin
      if (m_phase == 4 && opcode == 3'd0) m_halted = 1'b1;
      else begin
        if (m_phase == 7) m_retired = (m_retired + 1) % 65536;
        m_phase = (m_phase + 1) % 8;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; opcode = 3'd2; zero = 1'b0; resume = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (phase !== 3'd0 || halted !== 1'b0 || retired !== 16'd0)
      $display("FAIL reset_state: phase=%0d halted=%0b retired=%0d want 0/0/0",
               phase, halted, retired);
    else n_pass++;
    n_checks++;
    if (ctrl !== 9'b1_0000_0000) $display("FAIL reset_ctrl: got %b want %b", ctrl, 9'b1_0000_0000);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if (phase !== 3'd0) $display("FAIL reset_hold_phase: got %0d want 0", phase);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (phase !== 3'd0 || ctrl !== 9'b1_0000_0000)
      $display("FAIL reset_release: phase=%0d ctrl=%b want 0 / %b", phase, ctrl, 9'b1_0000_0000);
    else n_pass++;
  endtask

  task automatic test_add_sequence();
    int bad = 0;
    en = 1'b1; opcode = 3'd2;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (phase !== 3'(i % 8) || ld_ac !== (i % 8 == 7)) begin
        bad++;
        $display("FAIL add_seq cycle %0d: phase=%0d ld_ac=%0b want %0d/%0b",
                 i, phase, ld_ac, i % 8, (i % 8 == 7));
      end
      tick();
    end
    n_checks++;
    if (bad == 0) n_pass++;
    n_checks++;
    if (retired !== 16'd2) $display("FAIL add_retired: got %0d want 2", retired);
    else n_pass++;
  endtask

  task automatic test_skz();
    logic [7:0] mask;
    opcode = 3'd1;
    for (int zr = 1; zr >= 0; zr--) begin
      zero = 1'(zr);
      mask = '0;
      for (int p = 0; p < 8; p++) begin
        #1;
        mask[phase] = mask[phase] | inc_pc;
        tick();
      end
      n_checks++;
      if (mask !== (zr ? 8'b0101_0000 : 8'b0001_0000))
        $display("FAIL skz_inc_pc zero=%0d: phases %b want %b", zr, mask,
                 zr ? 8'b0101_0000 : 8'b0001_0000);
      else n_pass++;
    end
    zero = 1'b0;
  endtask

  task automatic test_sto();
    logic [7:0] de_m, wr_m, rd_m;
    opcode = 3'd6;
    de_m = '0; wr_m = '0; rd_m = '0;
    for (int p = 0; p < 8; p++) begin
      #1;
      de_m[phase] = data_e; wr_m[phase] = wr; rd_m[phase] = rd;
      tick();
    end
    n_checks++;
    if (de_m !== 8'b1100_0000) $display("FAIL sto_data_e: phases %b want 11000000", de_m);
    else n_pass++;
    n_checks++;
    if (wr_m !== 8'b1000_0000) $display("FAIL sto_wr: phases %b want 10000000", wr_m);
    else n_pass++;
    n_checks++;
    if (rd_m !== 8'b0000_1110) $display("FAIL sto_rd: phases %b want 00001110", rd_m);
    else n_pass++;
  endtask

  task automatic test_hlt();
    int ret0 = m_retired;
    int bad = 0;
    opcode = 3'd0;
    for (int p = 0; p < 4; p++) tick();
    #1;
    n_checks++;
    if (phase !== 3'd4 || halt !== 1'b1) $display("FAIL hlt_ph4: phase=%0d halt=%0b want 4/1", phase, halt);
    else n_pass++;
    tick();
    for (int i = 0; i < 10; i++) begin
      en = 1'($urandom_range(0, 1));
      #1;
      if (halted !== 1'b1 || phase !== 3'd4 || ctrl !== 9'b0_0001_0000) begin
        bad++;
        $display("FAIL hlt_hold %0d: halted=%0b phase=%0d ctrl=%b", i, halted, phase, ctrl);
      end
      tick();
    end
    n_checks++;
    if (bad == 0) n_pass++;
    en = 1'b1; resume = 1'b1;
    tick();
    resume = 1'b0;
    #1;
    n_checks++;
    if (phase !== 3'd0 || halted !== 1'b0) $display("FAIL hlt_resume: phase=%0d halted=%0b want 0/0", phase, halted);
    else n_pass++;
    n_checks++;
    if (retired !== 16'(ret0)) $display("FAIL hlt_retired: got %0d want %0d", retired, ret0);
    else n_pass++;
  endtask

  task automatic test_en_hold_jmp();
    int bad = 0;
    en = 1'b1; opcode = 3'd7;
    for (int p = 0; p < 7; p++) tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (phase !== 3'd7 || ld_pc !== 1'b0) begin
        bad++;
        $display("FAIL jmp_hold %0d: phase=%0d ld_pc=%0b want 7/0", i, phase, ld_pc);
      end
      tick();
    end
    n_checks++;
    if (bad == 0) n_pass++;
    en = 1'b1;
    #1;
    n_checks++;
    if (phase !== 3'd7 || ld_pc !== 1'b1) $display("FAIL jmp_release: phase=%0d ld_pc=%0b want 7/1", phase, ld_pc);
    else n_pass++;
    tick();
    n_checks++;
    if (phase !== 3'd0 || ld_pc !== 1'b0) $display("FAIL jmp_wrap: phase=%0d ld_pc=%0b want 0/0", phase, ld_pc);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    rst_n = 1'b0; model_reset();
    #1 rst_n = 1'b1;
    en = 1'b1; opcode = 3'd2;
    for (int i = 0; i < 46; i++) tick();
    n_checks++;
    if (phase !== 3'd6 || retired !== 16'd5) $display("FAIL arst_setup: phase=%0d retired=%0d want 6/5", phase, retired);
    else n_pass++;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (phase !== 3'd0 || retired !== 16'd0 || halted !== 1'b0 || ctrl !== 9'b1_0000_0000)
      $display("FAIL arst_mid: phase=%0d retired=%0d halted=%0b ctrl=%b", phase, retired, halted, ctrl);
    else n_pass++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int bad = 0;
    logic [8:0] want;
    for (int i = 0; i < 3000; i++) begin
      opcode = 3'($urandom_range(0, 7));
      zero   = 1'($urandom_range(0, 1));
      en     = ($urandom_range(0, 99) < 85);
      resume = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0; model_reset();
        #1;
        if (phase !== 3'd0 || halted !== 1'b0 || retired !== 16'd0) begin
          bad++;
          $display("FAIL rand_arst %0d: phase=%0d halted=%0b retired=%0d", i, phase, halted, retired);
        end
        rst_n = 1'b1;
      end
      #1;
      want = exp_ctrl(m_phase, m_halted, opcode, zero, en);
      if (phase !== 3'(m_phase) || halted !== m_halted || retired !== 16'(m_retired) ||
          ctrl !== want) begin
        bad++;
        $display("FAIL rand %0d: phase=%0d/%0d halted=%0b/%0b retired=%0d/%0d ctrl=%b/%b",
                 i, phase, m_phase, halted, m_halted, retired, m_retired, ctrl, want);
      end
      tick();
    end
    n_checks++;
    if (bad == 0) n_pass++;
    resume = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_sequence();
    test_skz();
    test_sto();
    test_hlt();
    test_en_hold_jmp();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
